timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank.sv | 186 ++++++++++++++++++
 tb/tb_timer_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
//   A bank of independent down-counting timers behind a 16-bit word-addressed
//   register file. Each channel has a prescaler, a reload value, a live counter
//   and a pending flag. A channel can run periodically or as a one-shot, and it
//   raises a level interrupt when its pending flag and interrupt enable are set.
//
//   Register map per channel (word address = {channel, reg}):
//     0 CTRL   : [0] EN, [1] ONESHOT, [2] IE, [15:8] PRESCALE
//     1 RELOAD : [CNT_W-1:0] reload value
//     2 COUNT  : [CNT_W-1:0] live counter (write loads it, clears prescaler)
//     3 STATUS : [0] PEND (write 1 to clear), [1] EN (read-only mirror)
//
// Ports
//   clk_i      : clock, all state changes on the rising edge
//   reset_i    : asynchronous active-high reset
//   addr_i     : word address, channel = addr_i[ADDR_W-1:2], reg = addr_i[1:0]
//   data_i     : write data
//   write_i    : single-cycle write strobe
//   read_i     : single-cycle read strobe
//   data_o     : registered read data, updated only by a read
//   irq_o      : per-channel interrupt, PEND & IE
//   irq_any_o  : OR of irq_o
// -----------------------------------------------------------------------------
module timer_bank #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16,
   parameter int ADDR_W   = 5
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [15:0]         data_i,
   input  logic                write_i,
   input  logic                read_i,
   output logic [15:0]         data_o,
   output logic [CHANNELS-1:0] irq_o,
   output logic                irq_any_o
);

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_RELOAD = 2'd1,
      REG_COUNT  = 2'd2,
      REG_STATUS = 2'd3
   } reg_sel_e;

   typedef struct packed {
      logic [7:0] prescale;
      logic       ie;
      logic       oneshot;
      logic       en;
   } ctrl_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [ADDR_W-3:0]   ch_idx;
   reg_sel_e            reg_sel;
   logic [CHANNELS-1:0] hit;
   logic [15:0]         rd_word [CHANNELS];
   logic [15:0]         rd_data;

   assign ch_idx  = addr_i[ADDR_W-1:2];
   assign reg_sel = reg_sel_e'(addr_i[1:0]);

   // CTRL bits [7:3] have no function; they are accepted and dropped.
   logic unused_data;
   assign unused_data = ^data_i[7:3];

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      ctrl_t            ctrl;
      logic [CNT_W-1:0] reload;
      logic [CNT_W-1:0] count;
      logic [7:0]       presc;
      logic             pend;

      logic             wr_ctrl;
      logic             wr_reload;
      logic             wr_count;
      logic             wr_status;
      logic             tick;
      logic             expire;
      logic [15:0]      word;

      // Out-of-range channel indices never match any g, so they read 0 and
      // their writes fall on the floor.
      assign hit[g]    = (int'(ch_idx) == g);
      assign wr_ctrl   = write_i && hit[g] && (reg_sel == REG_CTRL);
      assign wr_reload = write_i && hit[g] && (reg_sel == REG_RELOAD);
      assign wr_count  = write_i && hit[g] && (reg_sel == REG_COUNT);
      assign wr_status = write_i && hit[g] && (reg_sel == REG_STATUS);

      assign tick   = ctrl.en && (presc == ctrl.prescale);
      // A COUNT write on a tick cycle takes precedence, so it suppresses the
      // expiry side effects (PEND set, reload, one-shot disable).
      assign expire = tick && !wr_count && (count == '0);

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others, independent of statement order.
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            // NOTE: every channel register is reset, not just the enables; a
            // stale COUNT or PEND would otherwise leak out after reset release.
            ctrl   <= '0;
            reload <= '0;
            count  <= '0;
            presc  <= '0;
            pend   <= 1'b0;
         end else begin
            // Prescaler: restarts on COUNT write, on EN 0->1, and after each tick.
            if (wr_count || (wr_ctrl && data_i[0] && !ctrl.en) || tick) begin
               presc <= '0;
            end else if (ctrl.en) begin
               presc <= presc + 8'd1;
            end

            if (wr_count) begin
               count <= data_i[CNT_W-1:0];
            end else if (tick) begin
               if (count != '0) begin
                  count <= count - CNT_ONE;
               end else if (!ctrl.oneshot) begin
                  count <= reload;
               end
            end

            if (wr_reload) begin
               reload <= data_i[CNT_W-1:0];
            end

            // A CTRL write overrides the one-shot auto-disable; both paths
            // leave EN at 0 when software is clearing it.
            if (wr_ctrl) begin
               ctrl <= '{prescale: data_i[15:8], ie: data_i[2],
                         oneshot: data_i[1], en: data_i[0]};
            end else if (expire && ctrl.oneshot) begin
               ctrl.en <= 1'b0;
            end

            // Setting wins over a simultaneous write-1-to-clear.
            if (expire) begin
               pend <= 1'b1;
            end else if (wr_status && data_i[0]) begin
               pend <= 1'b0;
            end
         end
      end

      // NOTE: combinational blocks assign a default first so no path leaves
      // the output unassigned, which would infer a latch.
      always_comb begin
         word = '0;
         unique case (reg_sel)
            REG_CTRL:   word = {ctrl.prescale, 5'b0, ctrl.ie, ctrl.oneshot, ctrl.en};
            REG_RELOAD: word[CNT_W-1:0] = reload;
            REG_COUNT:  word[CNT_W-1:0] = count;
            REG_STATUS: word[1:0] = {ctrl.en, pend};
         endcase
      end

      assign rd_word[g] = word;
      assign irq_o[g]   = pend & ctrl.ie;
   end

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (hit[c]) begin
            rd_data = rd_word[c];
         end
      end
   end

   // Read data is captured from the pre-edge register values, so a read
   // coinciding with a write to the same register returns the old value.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         data_o <= '0;
      end else if (read_i) begin
         data_o <= rd_data;
      end
   end

   assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
//   Self-checking bench for timer_bank (CHANNELS=4, CNT_W=16, ADDR_W=5).
//   Inputs are driven on the falling edge and outputs sampled on the falling
//   edge, so every step below covers exactly one rising edge. Expected
//   interrupt timing in the randomized section is computed from the period
//   rule (COUNT+1)*(PRESCALE+1) for the first expiry and
//   (RELOAD+1)*(PRESCALE+1) thereafter.
// -----------------------------------------------------------------------------
module tb_timer_bank;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [4:0]  addr_i;
   logic [15:0] data_i;
   logic        write_i;
   logic        read_i;
   logic [15:0] data_o;
   logic [3:0]  irq_o;
   logic        irq_any_o;

   int n_assert = 0;
   int n_fail   = 0;

   timer_bank #(.CHANNELS(4), .CNT_W(16), .ADDR_W(5)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .write_i   (write_i),
      .read_i    (read_i),
      .data_o    (data_o),
      .irq_o     (irq_o),
      .irq_any_o (irq_any_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One rising edge with the given strobes; returns on the following falling edge.
   task automatic step(input logic wr, input logic rd, input int ch, input int r,
                       input logic [15:0] d);
      write_i = wr;
      read_i  = rd;
      addr_i  = 5'(ch * 4 + r);
      data_i  = d;
      @(negedge clk_i);
      write_i = 1'b0;
      read_i  = 1'b0;
   endtask

   task automatic wr(input int ch, input int r, input logic [15:0] d);
      step(1'b1, 1'b0, ch, r, d);
   endtask

   task automatic rd(input int ch, input int r);
      step(1'b0, 1'b1, ch, r, 16'h0000);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 0, 16'h0000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_i = 1'b1;
      addr_i  = '0;
      data_i  = '0;
      write_i = 1'b0;
      read_i  = 1'b0;

      // ---- reset state ----
      @(negedge clk_i);
      check("reset data_o", data_o, 0);
      check("reset irq_o", irq_o, 0);
      check("reset irq_any_o", irq_any_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      rd(0, 0);
      check("reset ch0 CTRL", data_o, 0);

      // ---- ch0 periodic, RELOAD=3, COUNT=3, PRESCALE=0 ----
      wr(0, 1, 16'd3);
      wr(0, 2, 16'd3);
      wr(0, 0, 16'h0005);
      for (int k = 1; k <= 4; k++) begin
         idle();
         check($sformatf("ch0 first expiry k=%0d", k), irq_o[0], (k >= 4));
      end
      check("ch0 irq_any", irq_any_o, 1);
      idle();
      wr(0, 3, 16'h0001);
      check("ch0 W1C clears", irq_o[0], 0);
      idle();
      check("ch0 quiet before period", irq_o[0], 0);
      idle();
      check("ch0 period of 4", irq_o[0], 1);
      idle();
      idle();
      idle();
      // W1C on the same edge as the next expiry
      wr(0, 3, 16'h0001);
      check("W1C vs expiry irq_o[0]", irq_o[0], 1);
      check("W1C vs expiry irq_any", irq_any_o, 1);
      wr(0, 3, 16'h0001);
      check("ch0 W1C after collision", irq_o[0], 0);
      idle();
      idle();
      // COUNT write on the expiry/tick edge
      wr(0, 2, 16'h0010);
      check("count write on tick no PEND", irq_o[0], 0);
      rd(0, 2);
      check("count write wins", data_o, 16'h0010);
      check("count write no PEND later", irq_o[0], 0);
      wr(0, 0, 16'h0000);
      rd(0, 3);
      check("ch0 STATUS after disable", data_o, 16'h0000);

      // ---- ch1 one-shot, PRESCALE=2, COUNT=1 ----
      wr(1, 2, 16'd1);
      wr(1, 0, 16'h0207);
      for (int k = 1; k <= 6; k++) begin
         idle();
         check($sformatf("ch1 oneshot k=%0d", k), irq_o[1], (k >= 6));
      end
      rd(1, 0);
      check("ch1 EN cleared", data_o, 16'h0206);
      rd(1, 2);
      check("ch1 COUNT 0", data_o, 16'h0000);
      repeat (10) idle();
      rd(1, 2);
      check("ch1 COUNT holds 0", data_o, 16'h0000);
      rd(1, 3);
      check("ch1 STATUS", data_o, 16'h0001);

      // ---- CTRL write clearing EN on a one-shot expiry edge ----
      wr(1, 3, 16'h0001);
      check("ch1 cleared", irq_o[1], 0);
      wr(1, 2, 16'd0);
      wr(1, 0, 16'h0007);
      wr(1, 0, 16'h0006);
      check("EN clear vs expiry PEND", irq_o[1], 1);
      rd(1, 0);
      check("EN clear vs expiry CTRL", data_o, 16'h0006);
      wr(1, 3, 16'h0001);
      wr(1, 0, 16'h0000);

      // ---- out-of-range channel 5 ----
      wr(2, 1, 16'h00A5);
      wr(3, 1, 16'h5A5A);
      rd(3, 1);
      check("ch3 RELOAD readback", data_o, 16'h5A5A);
      for (int r = 0; r < 4; r++) begin
         rd(5, r);
         check($sformatf("ch5 reg%0d reads 0", r), data_o, 16'h0000);
      end
      for (int r = 0; r < 4; r++) wr(5, r, 16'hFFFF);
      rd(1, 0);
      check("ch5 write: ch1 CTRL", data_o, 16'h0000);
      rd(1, 1);
      check("ch5 write: ch1 RELOAD", data_o, 16'h0000);
      rd(1, 2);
      check("ch5 write: ch1 COUNT", data_o, 16'h0000);
      rd(2, 1);
      check("ch5 write: ch2 RELOAD", data_o, 16'h00A5);
      rd(3, 1);
      check("ch5 write: ch3 RELOAD", data_o, 16'h5A5A);
      check("ch5 write: no irq", irq_o, 0);

      // ---- randomized periodic timing against the period rule ----
      for (int it = 0; it < 8; it++) begin
         int ch, p, c, r, first, per;
         logic [3:0] mask;
         ch    = $urandom_range(0, 3);
         p     = $urandom_range(0, 3);
         c     = $urandom_range(0, 4);
         r     = $urandom_range(0, 4);
         first = (c + 1) * (p + 1);
         per   = (r + 1) * (p + 1);
         mask  = 4'(1 << ch);
         wr(ch, 1, 16'(r));
         wr(ch, 2, 16'(c));
         wr(ch, 0, 16'((p << 8) | 5));
         for (int k = 1; k <= first; k++) begin
            idle();
            check($sformatf("rand%0d ch%0d p%0d c%0d first k=%0d", it, ch, p, c, k),
                  irq_o, (k >= first) ? mask : 4'h0);
         end
         wr(ch, 3, 16'h0001);
         check($sformatf("rand%0d ch%0d period j=1", it, ch), irq_o, (per == 1) ? mask : 4'h0);
         for (int j = 2; j <= per; j++) begin
            idle();
            check($sformatf("rand%0d ch%0d p%0d r%0d period j=%0d", it, ch, p, r, j),
                  irq_o, (j >= per) ? mask : 4'h0);
         end
         wr(ch, 0, 16'h0000);
         wr(ch, 3, 16'h0001);
         check($sformatf("rand%0d ch%0d quiet", it, ch), irq_o, 0);
         rd(ch, 1);
         check($sformatf("rand%0d ch%0d RELOAD", it, ch), data_o, 16'(r));
      end

      // ---- reset while ch2 counts, with ch3 pending ----
      wr(3, 2, 16'd0);
      wr(3, 0, 16'h0007);
      idle();
      check("ch3 pending before reset", irq_o, 4'b1000);
      wr(2, 1, 16'd5);
      wr(2, 2, 16'd5);
      wr(2, 0, 16'h0105);
      repeat (3) idle();
      rd(2, 1);
      check("ch2 RELOAD before reset", data_o, 16'd5);
      #2 reset_i = 1'b1;
      #1;
      check("async reset data_o", data_o, 0);
      check("async reset irq_o", irq_o, 0);
      check("async reset irq_any_o", irq_any_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      for (int k = 0; k < 100; k++) begin
         idle();
         check($sformatf("post-reset irq k=%0d", k), {irq_any_o, irq_o}, 0);
      end
      rd(2, 0);
      check("post-reset ch2 CTRL", data_o, 0);
      rd(2, 2);
      check("post-reset ch2 COUNT", data_o, 0);
      rd(3, 3);
      check("post-reset ch3 STATUS", data_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
